// File: rtl/ram_pkg.sv
// Purpose: shared constants, RAM pin encodings and FSM state types for the RAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_pkg;

  localparam int RAM_AW    = 3;
  localparam int RAM_DW    = 8;
  localparam int RAM_WORDS = 8;

  // Level on the RAM rws pin.
  localparam logic RWS_READ  = 1'b0;
  localparam logic RWS_WRITE = 1'b1;

  // Controller states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WSET,
    ST_WPUL,
    ST_WHLD,
    ST_RWAIT,
    ST_RCAP,
    ST_RRSP,
    ST_CSET,
    ST_CPUL,
    ST_CHLD
  } ctrl_state_t;

  // Write-strobe timer phases.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SET,
    PH_PUL,
    PH_HLD
  } stb_phase_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// Purpose: request/response handshake bundle between a requester and ram_ctrl.
// Latency: n/a (wires only); master = requester side, slave = controller side.
// Backpressure: req_valid/req_ready on requests, rsp_valid/rsp_ready on read data.
interface ram_ctrl_if;
  import ram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [RAM_AW-1:0] req_addr;
  logic [RAM_DW-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RAM_DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_strobe_gen.sv
// Purpose: write-strobe timer: one setup cycle, WR_PULSE cycles of rws high, one hold cycle.
// Latency: start -> rws high after 2 edges; phase sequence lasts WR_PULSE+2 cycles.
// Backpressure: none; start is only honoured in PH_IDLE or PH_HLD (back-to-back clear words).
// Ports: clk/rst; start (begin a sequence); rws (registered RAM strobe);
//        pul_last (final pulse cycle); done (hold cycle, sequence ends this cycle).
module ram_strobe_gen
  import ram_pkg::*;
#(
  parameter int WR_PULSE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic rws,
  output logic pul_last,
  output logic done
);

  stb_phase_t phase;
  logic [2:0] cnt;

  // rws is a flop of its own so the RAM pin can never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_IDLE;
      rws   <= RWS_READ;
      cnt   <= '0;
    end else begin
      case (phase)
        PH_IDLE: if (start) phase <= PH_SET;
        PH_SET: begin
          phase <= PH_PUL;
          rws   <= RWS_WRITE;
          cnt   <= '0;
        end
        PH_PUL: begin
          if (pul_last) begin
            phase <= PH_HLD;
            rws   <= RWS_READ;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        // A new start during hold chains straight into the next setup.
        PH_HLD:  phase <= start ? PH_SET : PH_IDLE;
        default: phase <= PH_IDLE;
      endcase
    end
  end

  assign pul_last = (phase == PH_PUL) && (cnt == 3'(WR_PULSE - 1));
  assign done     = (phase == PH_HLD);

endmodule

// File: rtl/ram_ctrl.sv
// Purpose: initiator-side controller for the 8x8 RAM macro: single reads/writes plus background clear.
// Latency: write accept->IDLE WR_PULSE+2 cycles; read accept->rsp_valid RD_WAIT+1 cycles after the accept edge.
// Backpressure: req_ready only in IDLE without clr_start; read data held until rsp_ready.
// Ports: clk/rst; bus (request/response handshake); clr_start/busy/clr_done (clear control);
//        ram_ins/ram_rws/ram_addr (registered RAM pins); ram_outs (RAM read data).
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_ctrl_if.slave         bus,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic [RAM_DW-1:0] ram_ins,
  output logic              ram_rws,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [RAM_DW-1:0] ram_outs
);

  ctrl_state_t       state;
  logic [2:0]        clr_cnt;
  logic [2:0]        rd_cnt;
  logic              rsp_valid_q;
  logic [RAM_DW-1:0] rsp_rdata_q;
  logic              stb_start;
  logic              stb_pul_last;
  logic              stb_done;
  logic              clr_last;

  assign clr_last      = (clr_cnt == 3'(RAM_WORDS - 1));
  // clr_start wins over a request arriving in the same IDLE cycle.
  assign bus.req_ready = (state == ST_IDLE) && !clr_start;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = (state != ST_IDLE);

  // Kick the strobe timer in the same cycle the FSM commits to a write or the next clear word.
  always_comb begin
    stb_start = 1'b0;
    if (state == ST_IDLE)
      stb_start = clr_start || (bus.req_valid && bus.req_we);
    else if (state == ST_CHLD)
      stb_start = !clr_last;
  end

  ram_strobe_gen #(.WR_PULSE(WR_PULSE)) u_stb (
    .clk      (clk),
    .rst      (rst),
    .start    (stb_start),
    .rws      (ram_rws),
    .pul_last (stb_pul_last),
    .done     (stb_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ram_addr    <= '0;
      ram_ins     <= '0;
      clr_cnt     <= '0;
      rd_cnt      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      clr_done    <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            clr_cnt  <= '0;
            ram_addr <= '0;
            ram_ins  <= '0;
            state    <= ST_CSET;
          end else if (bus.req_valid) begin
            ram_addr <= bus.req_addr;
            if (bus.req_we) begin
              ram_ins <= bus.req_wdata;
              state   <= ST_WSET;
            end else begin
              rd_cnt <= '0;
              state  <= ST_RWAIT;
            end
          end
        end
        ST_WSET: state <= ST_WPUL;
        ST_WPUL: if (stb_pul_last) state <= ST_WHLD;
        ST_WHLD: if (stb_done) state <= ST_IDLE;
        ST_RWAIT: begin
          if (rd_cnt == 3'(RD_WAIT - 1)) state <= ST_RCAP;
          else rd_cnt <= rd_cnt + 3'd1;
        end
        ST_RCAP: begin
          rsp_rdata_q <= ram_outs;
          rsp_valid_q <= 1'b1;
          state       <= ST_RRSP;
        end
        // rsp_rdata_q is left alone after the handshake.
        ST_RRSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_CSET: state <= ST_CPUL;
        ST_CPUL: if (stb_pul_last) state <= ST_CHLD;
        ST_CHLD: begin
          if (stb_done) begin
            if (clr_last) begin
              clr_done <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              clr_cnt  <= clr_cnt + 3'd1;
              ram_addr <= clr_cnt + 3'd1;
              state    <= ST_CSET;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Purpose: directed bench for ram_ctrl with a behavioural RAM and a read-data scoreboard.
// Latency: expected cycle positions are hand-derived from the state sequence (WR_PULSE=2, RD_WAIT=1).
// Backpressure: drives rsp_ready low to hold responses; requests wait on req_ready with a bound.
module tb_ram_ctrl;
  import ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_start;
  logic       busy;
  logic       clr_done;
  logic [7:0] ram_ins;
  logic       ram_rws;
  logic [2:0] ram_addr;
  logic [7:0] ram_outs;
  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  ram_ctrl_if bus ();

  ram_ctrl #(.WR_PULSE(2), .RD_WAIT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done),
    .ram_ins   (ram_ins),
    .ram_rws   (ram_rws),
    .ram_addr  (ram_addr),
    .ram_outs  (ram_outs)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: level-sensitive write sampled each rising edge, asynchronous read.
  always @(posedge clk) if (ram_rws) mem[ram_addr] <= ram_ins;
  assign ram_outs = mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every read handshake pops the next expected byte.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got %0h expected no response", bus.rsp_rdata);
      end else begin
        chk("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, return in the cycle after the accept edge.
  task automatic issue(input bit we, input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    if (!we) exp_q.push_back(exp_rd);
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_accept_timeout", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rws"},       32'(ram_rws),       32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
    chk({tag, "_clr_done"},  32'(clr_done),      32'd0);
    chk({tag, "_addr"},      32'(ram_addr),      32'd0);
    chk({tag, "_ins"},       32'(ram_ins),       32'd0);
  endtask

  initial begin
    int n;
    int hi;
    rst           = 1'b1;
    clr_start     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk_idle("reset");
    step();
    rst = 1'b0;
    step();

    // Write 0xA5 to addr 3: setup cycle 1, rws cycles 2-3, hold cycle 4, IDLE cycle 5.
    issue(1'b1, 3'd3, 8'hA5, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("wr_rws_c%0d", k), 32'(ram_rws), 32'((k == 2) || (k == 3)));
      chk($sformatf("wr_busy_c%0d", k), 32'(busy), 32'(k <= 4));
      if (k <= 4) begin
        chk($sformatf("wr_addr_c%0d", k), 32'(ram_addr), 32'd3);
        chk($sformatf("wr_ins_c%0d", k), 32'(ram_ins), 32'hA5);
      end
      step();
    end

    // Read addr 3, consumer ready: RWAIT cycle 1, RCAP cycle 2, rsp_valid cycle 3.
    issue(1'b0, 3'd3, 8'h00, 8'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("rd_valid_c%0d", k), 32'(bus.rsp_valid), 32'(k == 3));
      if (k == 3) chk("rd_rdata_c3", 32'(bus.rsp_rdata), 32'hA5);
      step();
    end
    wait_idle();

    // Read addr 3 with the consumer stalled for 5 cycles and a second read queued behind it.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 3'd3, 8'h00, 8'hA5);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 3'd3;
    exp_q.push_back(8'hA5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("stall_req_ready_c%0d", k), 32'(bus.req_ready), 32'd0);
      if (k >= 3) begin
        chk($sformatf("stall_valid_c%0d", k), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("stall_rdata_c%0d", k), 32'(bus.rsp_rdata), 32'hA5);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_ready_at_handshake", 32'(bus.req_ready), 32'd0);
    step();
    @(negedge clk);
    chk("stall_ready_after", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    wait_idle();

    // Fill every word with 0xFF, then clear and time clr_done.
    for (int a = 0; a < 8; a++) issue(1'b1, 3'(a), 8'hFF, 8'h00);
    wait_idle();
    clr_start = 1'b1;
    @(negedge clk);
    chk("clr_req_ready_c0", 32'(bus.req_ready), 32'd0);
    step();
    clr_start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!clr_done && n < 100) begin
      step();
      n++;
      @(negedge clk);
    end
    chk("clr_done_cycle", 32'(n), 32'd33);
    chk("clr_done_idle", 32'(busy), 32'd0);
    step();
    @(negedge clk);
    chk("clr_done_one_cycle", 32'(clr_done), 32'd0);
    step();
    for (int a = 0; a < 8; a++) issue(1'b0, 3'(a), 8'h00, 8'h00);
    wait_idle();

    // clr_start and a write together: clear runs, request held off until the clr_done cycle.
    clr_start     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd6;
    bus.req_wdata = 8'h5A;
    n  = 0;
    hi = 0;
    @(negedge clk);
    while (!clr_done && n < 100) begin
      if (bus.req_ready) hi++;
      step();
      clr_start = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("clrreq_ready_high_cycles", 32'(hi), 32'd0);
    chk("clrreq_accept_cycle", 32'(n), 32'd33);
    chk("clrreq_ready_at_done", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    wait_idle();
    issue(1'b0, 3'd6, 8'h00, 8'h5A);
    wait_idle();

    // Reset during the write pulse.
    issue(1'b1, 3'd2, 8'h11, 8'h00);
    step();
    @(negedge clk);
    chk("rstwr_rws_before", 32'(ram_rws), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rstwr");
    step();

    // Reset during word 4 of a clear (word 4 pulse occupies cycles 18-19).
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (17) step();
    @(negedge clk);
    chk("rstclr_rws_before", 32'(ram_rws), 32'd1);
    chk("rstclr_addr_before", 32'(ram_addr), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rstclr");
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      @(negedge clk);
      if (clr_done) hi++;
    end
    chk("rstclr_no_clr_done", 32'(hi), 32'd0);

    // Read after the resets still works on an untouched word.
    step();
    issue(1'b0, 3'd6, 8'h00, 8'h5A);
    wait_idle();
    repeat (2) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
